interconn_sched: RTL and testbench
==================================

# interconn_sched

Transfer scheduler in front of `interconn_priority`. It shares the N×N MVU interconnect between N requesting MVUs. Each requester gets a small transfer queue. Every cycle the block grants a conflict-free subset of queue heads, meaning no two grants target the same destination, using round-robin priority. Granted heads drive the interconnect `send_*` ports from registers.

## Interface
- `N`, 8, number of MVUs / requesters / destinations
- `W`, 64, data word width
- `BADDR`, 15, destination memory address width
- `QDEPTH`, 4, per-requester queue depth (power of 2, ≥2)

- `clk`  in  1  single clock; all logic on rising edge
- `clr`  in  1  reset, synchronous, active-high
- `req_valid[N]`  in  1 each  requester i offers a transfer
- `req_ready[N]`  out  1 each  = queue i not full and `clr`=0 (combinational)
- `req_to[N]`  in  N each  destination mask; one-hot or multicast
- `req_addr[N]`  in  BADDR each  destination address
- `req_word[N]`  in  W each  payload
- `send_to[N]`, `send_en[N]`, `send_addr[N]`, `send_word[N]`  out  N/1/BADDR/W each  registered drive into `interconn_priority`
- `conflict_cnt`  out  32  saturating count of cycles in which ≥1 non-empty head was not granted

## Operation
- Enqueue into queue i on a rising edge with `req_valid[i] && req_ready[i]`. Entry = {to, addr, word}.
- `req_ready[i]` depends only on the registered occupancy. A full queue does not accept in the same cycle it dequeues.
- Arbitration is combinational over the N heads.
  - Scan order: `rr_ptr`, `rr_ptr+1`, … mod N.
  - Head j is granted if its mask does not overlap the OR of the masks already granted this cycle.
- Each granted head dequeues at the edge. Its fields load into `send_*[j]` with `send_en[j]`=1.
- Any requester not granted gets `send_en`=0 at that edge. `send_to`, `send_addr` and `send_word` hold their previous values.
- A head whose `to` is 0 is dequeued and dropped: no grant, no `send_en`, and it does not block others.
- `rr_ptr` update: if ≥1 grant, `rr_ptr` ← (first granted index in scan order + 1) mod N. Otherwise it is unchanged.
- Guarantees:
  - Starvation bound: any non-empty head is granted within N arbitration cycles.
  - Per-source order is preserved.
- `conflict_cnt` increments when any non-zero-mask head is left ungranted. It saturates at 2^32-1.

## Timing
- Reset values: all `send_en`=0, `send_to`=0, `send_addr`=0, `send_word`=0; `conflict_cnt`=0; `rr_ptr`=0; all queues empty. `req_ready`=0 while `clr`=1.
- Latency, uncontested: enqueue at edge k; `send_en[i]`=1 during the cycle following edge k+1. `interconn_priority` then adds its own latency.
- `send_en[i]` is a one-cycle pulse per transfer. Back-to-back grants give consecutive pulses.
- Throughput: up to N transfers per cycle when masks are disjoint.
- `clr` asserted mid-operation: at that edge all queues are flushed and all outputs take reset values. Discarded entries are never emitted.
- Wrap-around: queue pointers are log2(QDEPTH) bits. An extra occupancy bit distinguishes full from empty.

## Structure
- Package `interconn_pkg`:
  - `typedef struct packed {logic [N-1:0] to; logic [BADDR-1:0] addr; logic [W-1:0] word;} xfer_t` (parameterised via package constants matching defaults)
  - constant `CONFLICT_CNT_W = 32`
- Sub-module `interconn_req_fifo`: QDEPTH-entry synchronous FIFO of `xfer_t` with `full`/`empty`/`push`/`pop`. Instantiated N times.
- Arbiter, `rr_ptr` and output registers live in the top.

## Test plan
- Single: after reset, req 2 → `to`=8'h10, `addr`=15'h0003, `word`=64'hdeadbeefdeadbeef. Expect `send_en[2]` for exactly one cycle, 2 edges after enqueue, with matching fields; `rr_ptr`=3.
- Conflict: `rr_ptr`=0; reqs 0 and 5 both → `to`=8'h08 in the same cycle. Expect req 0 granted first, req 5 on the next cycle, `conflict_cnt`=1.
- Disjoint all-to-all: every req i → 1<<((i+1)%8) in the same cycle. Expect all 8 `send_en` high in the same cycle, `conflict_cnt`=0.
- Multicast: req1 → 8'h0F, req2 → 8'h30, req3 → 8'h01 together. Expect 1 and 2 granted together, 3 one cycle later.
- Backpressure: reqs 0 and 1 each stream 8 words to 8'h10 with `valid` held high.
  - Grants alternate between 0 and 1.
  - `req_ready` drops when a queue holds 4 entries.
  - All 16 words are delivered in per-source order.
  - Zero-mask entries inserted mid-stream are dropped silently.
- Reset mid-flight: 3 entries queued in req 4, assert `clr` for 1 cycle. Expect all `send_en`=0 and nothing emitted after `clr` is released.

Source files
------------

// File: rtl/interconn_pkg.sv
// Shared types and constants for the interconnect transfer scheduler.
package interconn_pkg;

  localparam int unsigned N              = 8;
  localparam int unsigned W              = 64;
  localparam int unsigned BADDR          = 15;
  localparam int unsigned CONFLICT_CNT_W = 32;
  localparam int unsigned PTR_W          = $clog2(N);

  typedef struct packed {
    logic [N-1:0]     to;
    logic [BADDR-1:0] addr;
    logic [W-1:0]     word;
  } xfer_t;

  // Round-robin successor of a requester index.
  function automatic logic [PTR_W-1:0] rr_succ(input logic [PTR_W-1:0] idx);
    return PTR_W'((32'(idx) + 1) % N);
  endfunction

endpackage

// File: rtl/interconn_sched_if.sv
// Requester-side handshake and interconnect drive bundle for interconn_sched.
interface interconn_sched_if;
  import interconn_pkg::*;

  logic [N-1:0]                      req_valid;
  logic [N-1:0]                      req_ready;
  logic [N-1:0][N-1:0]               req_to;
  logic [N-1:0][BADDR-1:0]           req_addr;
  logic [N-1:0][W-1:0]               req_word;

  logic [N-1:0][N-1:0]               send_to;
  logic [N-1:0]                      send_en;
  logic [N-1:0][BADDR-1:0]           send_addr;
  logic [N-1:0][W-1:0]               send_word;

  logic [CONFLICT_CNT_W-1:0]         conflict_cnt;

  modport master (
    output req_valid, req_to, req_addr, req_word,
    input  req_ready, send_to, send_en, send_addr, send_word, conflict_cnt
  );

  modport slave (
    input  req_valid, req_to, req_addr, req_word,
    output req_ready, send_to, send_en, send_addr, send_word, conflict_cnt
  );
endinterface

// File: rtl/interconn_req_fifo.sv
// Per-requester synchronous transfer queue; pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate counter.
module interconn_req_fifo
  import interconn_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  clk,
  input  logic  clr,
  input  logic  push,
  input  logic  pop,
  input  xfer_t din,
  output xfer_t dout,
  output logic  full,
  output logic  empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  xfer_t         mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer update; a full queue never accepts, even while it is popping.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (!clr && push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/interconn_sched.sv
// Transfer scheduler: per-requester queues, round-robin conflict-free
// arbitration over queue heads, registered drive into the interconnect.
module interconn_sched
  import interconn_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic              clk,
  input  logic              clr,
  interconn_sched_if.slave  bus
);

  logic [N-1:0]              full;
  logic [N-1:0]              empty;
  logic [N-1:0]              push;
  logic [N-1:0]              grant;
  logic [N-1:0]              drop;
  xfer_t                     head [N];

  logic [PTR_W-1:0]          rr_ptr;
  logic [PTR_W-1:0]          first_idx;
  logic [PTR_W-1:0]          idx;
  logic [N-1:0]              taken;
  logic                      found;
  logic                      conflict;
  logic [CONFLICT_CNT_W-1:0] conflict_q;

  assign bus.req_ready    = ~full & {N{~clr}};
  assign push             = bus.req_valid & bus.req_ready;
  assign bus.conflict_cnt = conflict_q;

  for (genvar i = 0; i < N; i++) begin : g_q
    xfer_t din;
    assign din = '{to: bus.req_to[i], addr: bus.req_addr[i], word: bus.req_word[i]};

    interconn_req_fifo #(.DEPTH(QDEPTH)) u_fifo (
      .clk   (clk),
      .clr   (clr),
      .push  (push[i]),
      .pop   (grant[i] | drop[i]),
      .din   (din),
      .dout  (head[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  // Greedy scan from rr_ptr: grant a head when its mask is disjoint from all
  // masks already granted; zero-mask heads are discarded without a grant.
  always_comb begin
    grant     = '0;
    drop      = '0;
    taken     = '0;
    found     = 1'b0;
    first_idx = rr_ptr;
    conflict  = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PTR_W'((32'(rr_ptr) + k) % N);
      if (!empty[idx]) begin
        if (head[idx].to == '0) begin
          drop[idx] = 1'b1;
        end else if ((head[idx].to & taken) == '0) begin
          grant[idx] = 1'b1;
          taken      = taken | head[idx].to;
          if (!found) begin
            found     = 1'b1;
            first_idx = idx;
          end
        end else begin
          conflict = 1'b1;
        end
      end
    end
  end

  // Round-robin pointer and saturating conflict counter.
  always_ff @(posedge clk) begin
    if (clr) begin
      rr_ptr     <= '0;
      conflict_q <= '0;
    end else begin
      if (found) rr_ptr <= rr_succ(first_idx);
      if (conflict && (conflict_q != '1)) conflict_q <= conflict_q + 1'b1;
    end
  end

  // Output registers: granted heads load, others hold fields with send_en low.
  always_ff @(posedge clk) begin
    if (clr) begin
      bus.send_en   <= '0;
      bus.send_to   <= '0;
      bus.send_addr <= '0;
      bus.send_word <= '0;
    end else begin
      bus.send_en <= grant;
      for (int unsigned k = 0; k < N; k++) begin
        if (grant[k]) begin
          bus.send_to[k]   <= head[k].to;
          bus.send_addr[k] <= head[k].addr;
          bus.send_word[k] <= head[k].word;
        end
      end
    end
  end

endmodule

// File: tb/tb_interconn_sched.sv
// Directed bench for interconn_sched: single-shot vector table plus
// hand-written backpressure and mid-flight reset sequences.
module tb_interconn_sched;
  import interconn_pkg::*;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  interconn_sched_if bus();

  interconn_sched #(.QDEPTH(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [N-1:0]        valid;
    logic [N-1:0][N-1:0] to;
    logic [2:0][N-1:0]   en;
    logic [31:0]         cnt;
    logic [PTR_W-1:0]    rr;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.req_to    = '0;
    bus.req_addr  = '0;
    bus.req_word  = '0;
  endtask

  function automatic logic [BADDR-1:0] addr_of(input int v, input int i);
    return (v == 0) ? 15'h0003 : 15'(v * 16 + i);
  endfunction

  function automatic logic [W-1:0] word_of(input int v, input int i);
    return (v == 0) ? 64'hdeadbeefdeadbeef : {32'hA5A50000 | 32'(v), 32'(i)};
  endfunction

  task automatic do_reset();
    clr = 1'b1;
    idle();
    #1;
    check("rst_ready_low", 64'(bus.req_ready), 64'h0);
    tick();
    clr = 1'b0;
    #1;
    check("rst_send_en",   64'(bus.send_en), 64'h0);
    check("rst_send_to",   64'(bus.send_to), 64'h0);
    check("rst_addr_or",   64'(|bus.send_addr), 64'h0);
    check("rst_word_or",   64'(|bus.send_word), 64'h0);
    check("rst_cnt",       64'(bus.conflict_cnt), 64'h0);
    check("rst_rr",        64'(dut.rr_ptr), 64'h0);
    check("rst_ready_hi",  64'(bus.req_ready), 64'hFF);
  endtask

  task automatic set_vec(input int v, input logic [N-1:0] valid, input logic [N-1:0] e0,
                         input logic [N-1:0] e1, input logic [N-1:0] e2,
                         input logic [31:0] cnt, input logic [PTR_W-1:0] rr);
    vecs[v].valid = valid;
    vecs[v].to    = '0;
    vecs[v].en[0] = e0;
    vecs[v].en[1] = e1;
    vecs[v].en[2] = e2;
    vecs[v].cnt   = cnt;
    vecs[v].rr    = rr;
  endtask

  // Backpressure model helpers: source 0 carries a zero-mask entry at slot 4.
  function automatic logic [W-1:0] bp_word(input int s, input int e);
    return {32'(s), 32'(e)};
  endfunction

  initial begin
    int grants;
    int occ1;
    int doubles;
    int idx [2];
    int nent [2];
    logic [1:0] acc;
    logic saw_full0;
    logic [N-1:0] seen;
    int s_exp;
    int r;
    int e_exp;

    clr = 1'b0;
    idle();

    // single, conflict, all-to-all, multicast, zero-mask, chain, wrap
    set_vec(0, 8'h04, 8'h04, 8'h00, 8'h00, 0, 3'd3);
    vecs[0].to[2] = 8'h10;
    set_vec(1, 8'h21, 8'h01, 8'h20, 8'h00, 1, 3'd6);
    vecs[1].to[0] = 8'h08; vecs[1].to[5] = 8'h08;
    set_vec(2, 8'hFF, 8'hFF, 8'h00, 8'h00, 0, 3'd1);
    for (int i = 0; i < 8; i++) vecs[2].to[i] = 8'(1 << ((i + 1) % 8));
    set_vec(3, 8'h0E, 8'h06, 8'h08, 8'h00, 1, 3'd4);
    vecs[3].to[1] = 8'h0F; vecs[3].to[2] = 8'h30; vecs[3].to[3] = 8'h01;
    set_vec(4, 8'h03, 8'h02, 8'h00, 8'h00, 0, 3'd2);
    vecs[4].to[0] = 8'h00; vecs[4].to[1] = 8'h01;
    set_vec(5, 8'hFF, 8'h01, 8'h02, 8'h04, 3, 3'd3);
    for (int i = 0; i < 8; i++) vecs[5].to[i] = 8'h01;
    set_vec(6, 8'hC1, 8'h41, 8'h80, 8'h00, 1, 3'd0);
    vecs[6].to[0] = 8'h40; vecs[6].to[6] = 8'h80; vecs[6].to[7] = 8'h80;

    for (int v = 0; v < 7; v++) begin
      do_reset();
      bus.req_valid = vecs[v].valid;
      for (int i = 0; i < 8; i++) begin
        bus.req_to[i]   = vecs[v].to[i];
        bus.req_addr[i] = addr_of(v, i);
        bus.req_word[i] = word_of(v, i);
      end
      tick();
      idle();
      for (int c = 0; c < 3; c++) begin
        tick();
        check($sformatf("v%0d_en%0d", v, c), 64'(bus.send_en), 64'(vecs[v].en[c]));
        for (int i = 0; i < 8; i++) begin
          if (vecs[v].en[c][i]) begin
            check($sformatf("v%0d_to%0d", v, i),   64'(bus.send_to[i]),   64'(vecs[v].to[i]));
            check($sformatf("v%0d_addr%0d", v, i), 64'(bus.send_addr[i]), 64'(addr_of(v, i)));
            check($sformatf("v%0d_word%0d", v, i), bus.send_word[i],      word_of(v, i));
          end
        end
      end
      check($sformatf("v%0d_cnt", v), 64'(bus.conflict_cnt), 64'(vecs[v].cnt));
      check($sformatf("v%0d_rr", v),  64'(dut.rr_ptr),        64'(vecs[v].rr));
    end

    // Backpressure: sources 0 and 1 stream to 8'h10 with valid held high.
    do_reset();
    idx[0] = 0; idx[1] = 0;
    nent[0] = 9; nent[1] = 8;
    grants = 0; occ1 = 0; doubles = 0; saw_full0 = 1'b0;
    for (int cyc = 0; cyc < 300 && grants < 16; cyc++) begin
      for (int s = 0; s < 2; s++) begin
        bus.req_valid[s] = (idx[s] < nent[s]);
        bus.req_to[s]    = (s == 0 && idx[s] == 4) ? 8'h00 : 8'h10;
        bus.req_addr[s]  = 15'(s * 32 + idx[s]);
        bus.req_word[s]  = bp_word(s, idx[s]);
      end
      #1;
      acc = bus.req_valid[1:0] & bus.req_ready[1:0];
      if (!bus.req_ready[0]) saw_full0 = 1'b1;
      tick();
      for (int s = 0; s < 2; s++) if (acc[s]) idx[s]++;
      occ1 = occ1 + int'(acc[1]) - int'(bus.send_en[1]);
      check("bp_ready1", 64'(bus.req_ready[1]), 64'(occ1 < 4));
      if (bus.send_en[0] && bus.send_en[1]) doubles++;
      for (int s = 0; s < 2; s++) begin
        if (bus.send_en[s] && grants < 16) begin
          s_exp = grants % 2;
          r     = grants / 2;
          e_exp = (s_exp == 0 && r >= 4) ? r + 1 : r;
          check($sformatf("bp_src%0d", grants),  64'(s), 64'(s_exp));
          check($sformatf("bp_word%0d", grants), bus.send_word[s], bp_word(s_exp, e_exp));
          grants++;
        end
      end
    end
    idle();
    check("bp_grants_total", 64'(grants), 64'd16);
    check("bp_no_double",    64'(doubles), 64'd0);
    check("bp_ready0_drop",  64'(saw_full0), 64'd1);
    tick();
    tick();
    check("bp_drained_en",    64'(bus.send_en), 64'h0);
    check("bp_drained_ready", 64'(bus.req_ready), 64'hFF);

    // Reset mid-flight: req 4 holds 3 entries behind contention on 8'h01.
    do_reset();
    bus.req_valid = 8'h1F;
    for (int i = 0; i < 5; i++) begin
      bus.req_to[i]   = 8'h01;
      bus.req_addr[i] = 15'(100 + i);
      bus.req_word[i] = 64'(200 + i);
    end
    tick();
    bus.req_valid = 8'h10;
    tick();
    tick();
    check("mr_pre_en", 64'(bus.send_en), 64'h02);
    idle();
    clr = 1'b1;
    #1;
    check("mr_ready_low", 64'(bus.req_ready), 64'h0);
    tick();
    check("mr_en",   64'(bus.send_en), 64'h0);
    check("mr_to",   64'(bus.send_to), 64'h0);
    check("mr_addr", 64'(|bus.send_addr), 64'h0);
    check("mr_word", 64'(|bus.send_word), 64'h0);
    check("mr_cnt",  64'(bus.conflict_cnt), 64'h0);
    check("mr_rr",   64'(dut.rr_ptr), 64'h0);
    clr = 1'b0;
    seen = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      seen = seen | bus.send_en;
    end
    check("mr_nothing_emitted", 64'(seen), 64'h0);
    check("mr_ready_after",     64'(bus.req_ready), 64'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
